// File: rtl/wb_scoreboard_pkg.sv
// Shared widths and helpers for the register-write scoreboard beside DE.
// Defaults describe the 32-entry integer register file of the 5-stage pipeline.
package wb_scoreboard_pkg;

    localparam int SB_REGWORDS      = 32;
    localparam int SB_REGNOBITS     = 5;
    localparam int SB_CNTBITS       = 2;
    localparam int SB_RETIRE_BYPASS = 1;
    localparam int SB_INFLIGHT_BITS = 4;
    localparam int SB_TOTAL_BITS    = 16;

    // Clamp the total writer count to the 4-bit inflight field.
    function automatic logic [SB_INFLIGHT_BITS-1:0] sat_inflight(
        input logic [SB_TOTAL_BITS-1:0] total
    );
        logic [SB_TOTAL_BITS-1:0] cap;
        cap = SB_TOTAL_BITS'((1 << SB_INFLIGHT_BITS) - 1);
        if (total > cap) begin
            return cap[SB_INFLIGHT_BITS-1:0];
        end
        return total[SB_INFLIGHT_BITS-1:0];
    endfunction

endpackage

// File: rtl/wb_scoreboard_sb_counter.sv
// Up/down saturating in-flight counter for one tracked destination.
// Simultaneous inc and dec cancel; a lone dec at zero holds and flags underflow.
module sb_counter
    import wb_scoreboard_pkg::*;
#(
    parameter int W = SB_CNTBITS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic         underflow_o
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i && count_q != CNT_MAX) begin
            count_d = count_q + W'(1);
        end else if (dec_i && !inc_i && count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o     = count_q;
    assign underflow_o = dec_i && !inc_i && (count_q == '0);

endmodule

// File: rtl/wb_scoreboard.sv
// Register/CSR write scoreboard: tracks writers issued from DE until WB retires them
// and stalls DE while a source operand (or destination counter capacity) is pending.
module wb_scoreboard
    import wb_scoreboard_pkg::*;
#(
    parameter int REGWORDS      = SB_REGWORDS,
    parameter int REGNOBITS     = SB_REGNOBITS,
    parameter int CNTBITS       = SB_CNTBITS,
    parameter int RETIRE_BYPASS = SB_RETIRE_BYPASS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 de_valid,
    input  logic                 de_flush,
    input  logic [REGNOBITS-1:0] de_rs1,
    input  logic [REGNOBITS-1:0] de_rs2,
    input  logic                 de_use_rs1,
    input  logic                 de_use_rs2,
    input  logic                 de_wr_reg,
    input  logic [REGNOBITS-1:0] de_rd,
    input  logic                 de_rd_csr,
    input  logic                 de_wr_csr,
    input  logic                 wb_wr_reg,
    input  logic [REGNOBITS-1:0] wb_wregno,
    input  logic                 wb_wr_csr,
    output logic                 stall_DE,
    output logic                 issue_fire,
    output logic [REGWORDS-1:0]  busy_vec,
    output logic [3:0]           inflight,
    output logic                 err_underflow
);

    localparam logic [CNTBITS-1:0] CNT_MAX = '1;
    localparam bit                 BYPASS  = (RETIRE_BYPASS != 0);

    logic [CNTBITS-1:0] cnt [REGWORDS];
    logic [CNTBITS-1:0] eff [REGWORDS];
    logic [REGWORDS-1:0] uf_vec;

    logic [CNTBITS-1:0] csr_cnt;
    logic [CNTBITS-1:0] eff_csr;
    logic               csr_uf;

    logic hazard;
    logic capacity;
    logic err_q;
    logic [SB_TOTAL_BITS-1:0] total;

    assign cnt[0]      = '0;
    assign eff[0]      = '0;
    assign uf_vec[0]   = 1'b0;
    assign busy_vec[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < REGWORDS; gi++) begin : g_reg
            logic hit_wb;
            logic hit_de;

            assign hit_wb = wb_wr_reg && (wb_wregno == REGNOBITS'(gi));
            assign hit_de = issue_fire && de_wr_reg && (de_rd == REGNOBITS'(gi));

            sb_counter #(
                .W (CNTBITS)
            ) u_cnt (
                .clk         (clk),
                .reset       (reset),
                .inc_i       (hit_de),
                .dec_i       (hit_wb),
                .count_o     (cnt[gi]),
                .underflow_o (uf_vec[gi])
            );

            // Bypass credits the retiring write early; a stray retire at zero stays zero.
            assign eff[gi]      = (BYPASS && hit_wb && cnt[gi] != '0) ? cnt[gi] - CNTBITS'(1) : cnt[gi];
            assign busy_vec[gi] = (cnt[gi] != '0);
        end
    endgenerate

    sb_counter #(
        .W (CNTBITS)
    ) u_csr_cnt (
        .clk         (clk),
        .reset       (reset),
        .inc_i       (issue_fire && de_wr_csr),
        .dec_i       (wb_wr_csr),
        .count_o     (csr_cnt),
        .underflow_o (csr_uf)
    );

    assign eff_csr = (BYPASS && wb_wr_csr && csr_cnt != '0) ? csr_cnt - CNTBITS'(1) : csr_cnt;

    assign hazard   = (de_use_rs1 && eff[de_rs1] != '0)
                    | (de_use_rs2 && eff[de_rs2] != '0)
                    | (de_rd_csr  && eff_csr     != '0);
    assign capacity = (de_wr_reg && de_rd != '0 && eff[de_rd] == CNT_MAX)
                    | (de_wr_csr && eff_csr == CNT_MAX);

    // Flush only squashes the DE instruction; older tracked writers still retire.
    assign stall_DE   = de_valid && !de_flush && (hazard || capacity);
    assign issue_fire = de_valid && !de_flush && !stall_DE;

    always_comb begin
        total = SB_TOTAL_BITS'(csr_cnt);
        for (int i = 1; i < REGWORDS; i++) begin
            total = total + SB_TOTAL_BITS'(cnt[i]);
        end
    end

    assign inflight = sat_inflight(total);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if ((|uf_vec) || csr_uf) begin
            err_q <= 1'b1;
        end
    end

    assign err_underflow = err_q;

endmodule
